// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states
// and small decode helpers used by both the sequencer and its iteration core.
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Datapath for the iterative multiply/divide: accumulator, latched operand and sign
// flags, one shift-add or restoring-divide step per strobe, and the sign-corrected result.
module muldiv_iter_core
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     diff_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;

    // Operand magnitudes for signed ops; the most negative value maps onto itself
    always_comb begin
        a_neg_s = op_is_signed(op) & a[WIDTH-1];
        b_neg_s = op_is_signed(op) & b[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = {WIDTH{1'b0}} - a;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = {WIDTH{1'b0}} - b;
        end else begin
            b_mag_s = b;
        end
    end

    // One iteration: multiplier bits shift out the bottom, quotient bits shift in
    always_comb begin
        if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
        end else begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        diff_s  = trial_s - {1'b0, opb_r};
        if (!is_div_r) begin
            acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
        end else if (diff_s[WIDTH]) begin
            acc_step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            acc_step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign-corrected result presented to the sequencer during FIX
    always_comb begin
        if (neg_res_r) begin
            prod_s = {(2*WIDTH){1'b0}} - acc_r;
            quo_s  = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[WIDTH-1:0];
        end
        if (neg_rem_r) begin
            rem_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
        end else begin
            rem_s = acc_r[2*WIDTH-1:WIDTH];
        end
        if (is_div_r) begin
            res_hi = rem_s;
            res_lo = quo_s;
        end else begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
        end
    end

    // Accumulator, operand and sign-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= {(2*WIDTH){1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (load) begin
            acc_r     <= {{WIDTH{1'b0}}, a_mag_s};
            opb_r     <= b_mag_s;
            is_div_r  <= op_is_div(op);
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
        end else if (step) begin
            acc_r <= acc_step_s;
        end else if (fix) begin
            acc_r <= {(2*WIDTH){1'b0}};
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: accepts MULT/MULTU/DIV/DIVU, runs the iteration
// core for WIDTH cycles, owns HI/LO, and interlocks later HI/LO users while busy.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             StartIn,
    input  logic [1:0]       OpIn,
    input  logic [WIDTH-1:0] OperandAIn,
    input  logic [WIDTH-1:0] OperandBIn,
    input  logic             FlushIn,
    input  logic             ReadHiLoIn,
    input  logic             WriteHiIn,
    input  logic             WriteLoIn,
    input  logic [WIDTH-1:0] WriteDataIn,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             BusyOut,
    output logic             StallOut,
    output logic             DoneOut,
    output logic             DivZeroOut
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic             idle_s;
    logic             accept_s;
    logic             div_zero_s;
    logic             write_hi_s;
    logic             write_lo_s;
    logic             load_s;
    logic             step_s;
    logic             fix_s;
    op_e              op_s;

    assign op_s     = op_e'(OpIn);
    assign idle_s   = (state_r == S_IDLE);
    assign accept_s = idle_s & StartIn & ~FlushIn;

    // A zero divisor is reported but never enters RUN; a start always beats MTHI/MTLO
    always_comb begin
        div_zero_s = accept_s & op_is_div(op_s) & (OperandBIn == {WIDTH{1'b0}});
        write_hi_s = idle_s & ~StartIn & ~FlushIn & WriteHiIn;
        write_lo_s = idle_s & ~StartIn & ~FlushIn & WriteLoIn;
    end

    assign StallOut = busy_r & (StartIn | ReadHiLoIn | WriteHiIn | WriteLoIn) & ~FlushIn;

    // Next-state decode and datapath strobes
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        fix_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s && !div_zero_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = S_FIX;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_FIX: begin
                fix_s       = 1'b1;
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Iteration counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (step_s) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Architectural HI/LO
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (fix_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else begin
            hi_r <= write_hi_s ? WriteDataIn : hi_r;
            lo_r <= write_lo_s ? WriteDataIn : lo_r;
        end
    end

    // Registered status outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            busy_r     <= (state_nxt_s != S_IDLE);
            done_r     <= fix_s;
            div_zero_r <= div_zero_s;
        end
    end

    assign HiOut      = hi_r;
    assign LoOut      = lo_r;
    assign BusyOut    = busy_r;
    assign DoneOut    = done_r;
    assign DivZeroOut = div_zero_r;

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (Clk),
        .rst    (Rst),
        .load   (load_s),
        .step   (step_s),
        .fix    (fix_s),
        .op     (op_s),
        .a      (OperandAIn),
        .b      (OperandBIn),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: an arithmetic reference model checked every
// cycle, plus hand-computed literal results for the listed scenarios.
module tb_muldiv_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        StartIn;
    logic [1:0]  OpIn;
    logic [31:0] OperandAIn;
    logic [31:0] OperandBIn;
    logic        FlushIn;
    logic        ReadHiLoIn;
    logic        WriteHiIn;
    logic        WriteLoIn;
    logic [31:0] WriteDataIn;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        BusyOut;
    logic        StallOut;
    logic        DoneOut;
    logic        DivZeroOut;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_busy_left;
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    logic        m_done, m_dz;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .StartIn(StartIn), .OpIn(OpIn),
        .OperandAIn(OperandAIn), .OperandBIn(OperandBIn), .FlushIn(FlushIn),
        .ReadHiLoIn(ReadHiLoIn), .WriteHiIn(WriteHiIn), .WriteLoIn(WriteLoIn),
        .WriteDataIn(WriteDataIn), .HiOut(HiOut), .LoOut(LoOut), .BusyOut(BusyOut),
        .StallOut(StallOut), .DoneOut(DoneOut), .DivZeroOut(DivZeroOut)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {HI, LO} computed with plain wide arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'h0, a} * {32'h0, b};
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            default: p = {a % b, a / b};
        endcase
        return p;
    endfunction

    // Reference model: busy for 33 cycles after accept, results land as busy drops
    always @(posedge Clk) begin
        if (Rst) begin
            m_busy_left = 0;
            m_hi = 32'h0; m_lo = 32'h0;
            m_done = 1'b0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_hi = m_pend_hi;
                    m_lo = m_pend_lo;
                    m_done = 1'b1;
                end
            end else if (StartIn && !FlushIn) begin
                if (OpIn[1] && OperandBIn == 32'h0) begin
                    m_dz = 1'b1;
                end else begin
                    {m_pend_hi, m_pend_lo} = ref_result(OpIn, OperandAIn, OperandBIn);
                    m_busy_left = 33;
                end
            end else if (!FlushIn) begin
                if (WriteHiIn) m_hi = WriteDataIn;
                if (WriteLoIn) m_lo = WriteDataIn;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            logic exp_busy;
            exp_busy = (m_busy_left > 0);
            check("hi", {32'h0, HiOut}, {32'h0, m_hi});
            check("lo", {32'h0, LoOut}, {32'h0, m_lo});
            check("busy", {63'h0, BusyOut}, {63'h0, exp_busy});
            check("stall", {63'h0, StallOut},
                  {63'h0, exp_busy & (StartIn | ReadHiLoIn | WriteHiIn | WriteLoIn) & ~FlushIn});
            check("done", {63'h0, DoneOut}, {63'h0, m_done});
            check("divzero", {63'h0, DivZeroOut}, {63'h0, m_dz});
        end
    end

    task automatic step_cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        StartIn = 1'b1; OpIn = op; OperandAIn = a; OperandBIn = b;
        step_cyc();
        StartIn = 1'b0;
    endtask

    // Returns at the negedge where BusyOut is low; counts busy and stalled cycles
    task automatic wait_idle(output int busy_n, output int stall_n);
        busy_n = 0;
        stall_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (!BusyOut) break;
            busy_n++;
            if (StallOut) stall_n++;
            @(posedge Clk);
            #1;
        end
        if (busy_n >= 200) begin
            check("busy_timeout", 64'(busy_n), 64'd33);
        end
    endtask

    int nb, ns;

    initial begin
        Rst = 1'b1; StartIn = 1'b0; OpIn = 2'b00; OperandAIn = 32'h0; OperandBIn = 32'h0;
        FlushIn = 1'b0; ReadHiLoIn = 1'b0; WriteHiIn = 1'b0; WriteLoIn = 1'b0;
        WriteDataIn = 32'h0;
        step_cyc();
        chk_en = 1'b1;
        step_cyc();
        Rst = 1'b0;
        @(negedge Clk);
        check("reset_busy", {63'h0, BusyOut}, 64'h0);
        check("reset_hilo", {HiOut, LoOut}, 64'h0);
        step_cyc();

        // MULT -3 * 7
        start_op(2'b00, 32'hFFFFFFFD, 32'h7);
        wait_idle(nb, ns);
        check("mult_busy_len", 64'(nb), 64'd33);
        check("mult_res", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFEB);
        check("mult_done", {63'h0, DoneOut}, 64'h1);
        step_cyc();

        // MULTU max * max, with a flush of a younger instruction mid-run
        start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) step_cyc();
        FlushIn = 1'b1;
        step_cyc();
        FlushIn = 1'b0;
        wait_idle(nb, ns);
        check("multu_res", {HiOut, LoOut}, 64'hFFFFFFFE_00000001);
        step_cyc();

        // DIV -7 / 2, then DIVU by zero
        start_op(2'b10, 32'hFFFFFFF9, 32'h2);
        wait_idle(nb, ns);
        check("div_res", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFFD);
        step_cyc();
        start_op(2'b11, 32'h5, 32'h0);
        @(negedge Clk);
        check("dz_pulse", {63'h0, DivZeroOut}, 64'h1);
        check("dz_busy", {63'h0, BusyOut}, 64'h0);
        check("dz_hilo", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFFD);
        step_cyc();

        // DIV overflow wraps
        start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(nb, ns);
        check("div_ovf", {HiOut, LoOut}, 64'h00000000_80000000);
        step_cyc();

        // MFHI/MFLO interlock after MULT
        start_op(2'b00, 32'h00010000, 32'h00010000);
        ReadHiLoIn = 1'b1;
        wait_idle(nb, ns);
        check("read_stall_len", 64'(ns), 64'd33);
        check("read_stall_drop", {63'h0, StallOut}, 64'h0);
        check("read_hi", {32'h0, HiOut}, 64'h1);
        step_cyc();
        ReadHiLoIn = 1'b0;

        // Second start while busy is held, then accepted on the first free cycle
        start_op(2'b11, 32'd100, 32'd7);
        StartIn = 1'b1; OpIn = 2'b01; OperandAIn = 32'd3; OperandBIn = 32'd5;
        wait_idle(nb, ns);
        check("start_stall_len", 64'(ns), 64'd33);
        check("divu_res", {HiOut, LoOut}, {32'd2, 32'd14});
        step_cyc();
        StartIn = 1'b0;
        wait_idle(nb, ns);
        check("held_start_busy", 64'(nb), 64'd33);
        check("held_start_res", {HiOut, LoOut}, {32'd0, 32'd15});
        step_cyc();

        // Reset during iteration 10 of a DIV
        start_op(2'b10, 32'd1000, 32'd3);
        repeat (10) step_cyc();
        Rst = 1'b1;
        ReadHiLoIn = 1'b1;
        step_cyc();
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_busy", {63'h0, BusyOut}, 64'h0);
        check("rst_stall", {63'h0, StallOut}, 64'h0);
        check("rst_hilo", {HiOut, LoOut}, 64'h0);
        step_cyc();
        ReadHiLoIn = 1'b0;
        start_op(2'b00, 32'd6, 32'd7);
        wait_idle(nb, ns);
        check("mult_6x7", {HiOut, LoOut}, {32'd0, 32'd42});
        step_cyc();

        // MTLO, flushed MTHI, and a start that beats a simultaneous MTLO
        WriteLoIn = 1'b1; WriteDataIn = 32'h12345678;
        step_cyc();
        WriteLoIn = 1'b0;
        @(negedge Clk);
        check("mtlo", {32'h0, LoOut}, 64'h12345678);
        step_cyc();
        WriteHiIn = 1'b1; FlushIn = 1'b1; WriteDataIn = 32'hDEADBEEF;
        step_cyc();
        WriteHiIn = 1'b0; FlushIn = 1'b0;
        @(negedge Clk);
        check("mthi_flushed", {32'h0, HiOut}, 64'h0);
        step_cyc();
        WriteLoIn = 1'b1; WriteDataIn = 32'h0000AAAA;
        start_op(2'b01, 32'd2, 32'd3);
        WriteLoIn = 1'b0;
        wait_idle(nb, ns);
        check("start_beats_mtlo", {HiOut, LoOut}, {32'd0, 32'd6});
        step_cyc();

        repeat (3) step_cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
